// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, key-shift schedule, FSM encoding
// and the bit-permutation helpers used by the round engine and key schedule.
package des_pkg;

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned KEY_W  = 64;
  localparam int unsigned HALF_W = 32;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned SUB_W  = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned RND_W  = 5;
  localparam int unsigned N_RND  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Tables use DES bit numbering: entry value 1 is the MSB of the source word.
  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int unsigned FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int unsigned SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_key_schedule.sv
// DES key schedule: holds C/D, rotates them once per round and presents the
// round key PC2(shifted CD) combinationally for the current round.
module des_key_schedule
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_load,
  input  logic [KEY_W-1:0] i_key,
  input  logic             i_step,
  input  logic             i_decrypt,
  input  logic [RND_W-1:0] i_rnd,
  output logic [RK_W-1:0]  o_k_c
);

  logic [SUB_W-1:0] r_c;
  logic [SUB_W-1:0] r_d;
  logic [3:0]       w_sidx;
  logic             w_two;
  logic             w_hold;
  logic [SUB_W-1:0] w_c_next;
  logic [SUB_W-1:0] w_d_next;

  // Decrypt walks the schedule backwards; its first round uses CD as loaded.
  assign w_sidx = i_decrypt ? 4'(5'd16 - i_rnd) : i_rnd[3:0];
  assign w_two  = (SHIFT_T[w_sidx] == 2);
  assign w_hold = i_decrypt && (i_rnd == '0);

  always_comb begin
    w_c_next = r_c;
    w_d_next = r_d;
    if (!w_hold) begin
      if (i_decrypt) begin
        w_c_next = rotr28(r_c, w_two);
        w_d_next = rotr28(r_d, w_two);
      end else begin
        w_c_next = rotl28(r_c, w_two);
        w_d_next = rotl28(r_d, w_two);
      end
    end
  end

  assign o_k_c = pc2_perm({w_c_next, w_d_next});

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_c <= '0;
      r_d <= '0;
    end else if (i_load) begin
      {r_c, r_d} <= pc1_perm(i_key);
    end else if (i_step) begin
      r_c <= w_c_next;
      r_d <= w_d_next;
    end
  end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES engine: one Feistel round per clock, S-box substitution done
// by an external block between sbox_in and sbox_out.
module des_round_engine
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              decrypt,
  input  logic [BLK_W-1:0]  data_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic [RK_W-1:0]   sbox_in,
  input  logic [HALF_W-1:0] sbox_out,
  output logic              busy,
  output logic              done,
  output logic [BLK_W-1:0]  data_out
);

  state_t              r_state;
  logic [HALF_W-1:0]   r_l;
  logic [HALF_W-1:0]   r_r;
  logic [RND_W-1:0]    r_rnd;
  logic                r_mode;
  logic                r_busy;
  logic                r_done;
  logic [BLK_W-1:0]    r_data_out;

  logic                w_load;
  logic                w_step;
  logic [RK_W-1:0]     w_k;
  logic [BLK_W-1:0]    w_ip;
  logic [HALF_W-1:0]   w_r_next;

  assign w_load   = (r_state == ST_IDLE) && start;
  assign w_step   = (r_state == ST_ROUND);
  assign w_ip     = ip_perm(data_in);
  assign w_r_next = r_l ^ p_perm(sbox_out);
  assign sbox_in  = w_step ? (e_exp(r_r) ^ w_k) : '0;

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

  des_key_schedule u_key_schedule (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_load    (w_load),
    .i_key     (key_in),
    .i_step    (w_step),
    .i_decrypt (r_mode),
    .i_rnd     (r_rnd),
    .o_k_c     (w_k)
  );

  // Control FSM and L/R datapath; done pulses on the DONE -> IDLE edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_l        <= '0;
      r_r        <= '0;
      r_rnd      <= '0;
      r_mode     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_l     <= w_ip[BLK_W-1:HALF_W];
            r_r     <= w_ip[HALF_W-1:0];
            r_mode  <= decrypt;
            r_rnd   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_l   <= r_r;
          r_r   <= w_r_next;
          r_rnd <= r_rnd + 1'b1;
          if (r_rnd == RND_W'(N_RND - 1)) begin
            // Final output swaps the halves before the inverse permutation.
            r_data_out <= fp_perm({w_r_next, r_r});
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: models the external S-box stage and checks
// results against known DES vectors through a scoreboard queue.
module tb_des_round_engine;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] data_in = '0;
  logic [63:0] key_in = '0;
  logic [47:0] sbox_in;
  logic [31:0] sbox_out;
  logic        busy;
  logic        done;
  logic [63:0] data_out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;  // KEY_A with every byte LSB flipped
  localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;

  // Eight standard S-boxes, row-major (row*16+col), entry 0 in the top nibble.
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  function automatic logic [31:0] sbox_f(input logic [47:0] x);
    logic [31:0] r;
    logic [5:0]  b;
    logic [7:0]  pos;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      b   = x[6'(47 - 6 * i) -: 6];
      pos = 8'(255 - 4 * int'({b[5], b[0], b[4:1]}));
      r[5'(31 - 4 * i) -: 4] = SB[3'(i)][pos -: 4];
    end
    return r;
  endfunction

  assign sbox_out = sbox_f(sbox_in);

  des_round_engine dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .decrypt  (decrypt),
    .data_in  (data_in),
    .key_in   (key_in),
    .sbox_in  (sbox_in),
    .sbox_out (sbox_out),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every done pulse must retire exactly one queued expectation.
  always @(negedge clk) begin
    if (n_rst && done) begin
      chk_eq("done_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) chk_eq("data_out", data_out, sb_q.pop_front());
    end
  end

  task automatic run_op(input logic dec, input logic [63:0] din, input logic [63:0] key,
                        input logic [63:0] exp, input bit disturb, input bit r1);
    int lat;
    sb_q.push_back(exp);
    decrypt = dec;
    data_in = din;
    key_in  = key;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = {$urandom, $urandom};
    key_in  = {$urandom, $urandom};
    decrypt = ~dec;
    if (r1) begin
      chk_eq("sbox_in_r1", 64'(sbox_in), 64'h6117BA866527);
      chk_eq("sbox_out_r1", 64'(sbox_out), 64'h5C82B597);
    end
    chk_eq("busy_round", 64'(busy), 64'd1);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      start = disturb && (n == 3 || n == 10);
      if (disturb) begin
        data_in = {$urandom, $urandom};
        key_in  = {$urandom, $urandom};
      end
      @(negedge clk);
      if (n == 16) begin
        chk_eq("busy_done_state", 64'(busy), 64'd1);
        chk_eq("done_early", 64'(done), 64'd0);
      end
      if (done) lat = n;
    end
    start = 1'b0;
    chk_eq("busy_idle", 64'(busy), 64'd0);
    chk_eq("latency", 64'(lat), 64'd17);
    if (lat == 0) sb_q.delete();
  endtask

  initial begin
    #1;
    chk_eq("rst_busy", 64'(busy), 64'd0);
    chk_eq("rst_done", 64'(done), 64'd0);
    chk_eq("rst_data_out", data_out, 64'd0);
    chk_eq("rst_sbox_in", 64'(sbox_in), 64'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    run_op(1'b0, PT_A, KEY_A, CT_A, 1'b0, 1'b1);
    chk_eq("idle_sbox_in", 64'(sbox_in), 64'd0);
    run_op(1'b1, CT_A, KEY_A, PT_A, 1'b0, 1'b0);
    run_op(1'b0, PT_A, KEY_A, CT_A, 1'b1, 1'b0);

    // Abort an operation part-way through with reset.
    repeat (3) @(negedge clk);
    chk_eq("data_out_held", data_out, CT_A);
    decrypt = 1'b0;
    data_in = PT_A;
    key_in  = KEY_A;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk_eq("busy_before_abort", 64'(busy), 64'd1);
    n_rst = 1'b0;
    #1;
    chk_eq("abort_data_out", data_out, 64'd0);
    chk_eq("abort_busy", 64'(busy), 64'd0);
    chk_eq("abort_done", 64'(done), 64'd0);
    chk_eq("abort_sbox_in", 64'(sbox_in), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (25) @(negedge clk);
    chk_eq("post_abort_data_out", data_out, 64'd0);
    run_op(1'b0, PT_A, KEY_A, CT_A, 1'b0, 1'b1);

    // Back-to-back operations on further known vectors.
    run_op(1'b0, 64'h0, 64'h0, 64'h8CA64DE9C1B123A7, 1'b0, 1'b0);
    run_op(1'b1, 64'h8CA64DE9C1B123A7, 64'h0, 64'h0, 1'b0, 1'b0);
    run_op(1'b0, 64'h8787878787878787, 64'h0E329232EA6D0D73, 64'h0, 1'b0, 1'b0);
    run_op(1'b1, 64'h0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 1'b0);
    run_op(1'b0, PT_A, KEY_P, CT_A, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk_eq("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
